// File: rtl/encoder_batch_sequencer.sv
// encoder_batch_sequencer
//   Steps the encoder through a batch of file indices over its start/finish
//   handshake. For each file it pulses enc_start for START_HOLD cycles and then
//   waits for a fresh rising finish. A per-file watchdog catches files that
//   never finish.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   go           batch start request (honoured in IDLE only)
//   abort        cancel the batch from any state; no done pulse
//   enc_finish   encoder finish level
//   enc_start    encoder start, high START_HOLD cycles per file
//   file_index   file index presented to the encoder
//   busy         high from the first START through DONE
//   done         one-cycle pulse at the end of a batch
//   files_done   files completed normally in the current/last batch
//   err_timeout  sticky timeout flag, cleared by go
//   timeout_idx  file_index of the most recent timeout
module encoder_batch_sequencer #(
  parameter int IDX_W      = 10,
  parameter int FIRST_IDX  = 0,
  parameter int NUM_FILES  = 8,
  parameter int START_HOLD = 3,
  parameter int TIMEOUT    = 4096,
  parameter int TO_W       = 16,
  parameter int STOP_ON_TO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic             enc_finish,
  output logic             enc_start,
  output logic [IDX_W-1:0] file_index,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] files_done,
  output logic             err_timeout,
  output logic [IDX_W-1:0] timeout_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [IDX_W-1:0]  FIRST     = IDX_W'(FIRST_IDX);
  localparam logic [IDX_W-1:0]  LAST      = IDX_W'(FIRST_IDX + NUM_FILES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam bit                TO_EN     = (TIMEOUT > 0);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit                STOP_EN   = (STOP_ON_TO != 0);

  state_t             state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic               armed_reg, armed_next;
  logic [IDX_W-1:0]   file_index_reg, file_index_next;
  logic [IDX_W-1:0]   files_done_reg, files_done_next;
  logic               err_timeout_reg, err_timeout_next;
  logic [IDX_W-1:0]   timeout_idx_reg, timeout_idx_next;
  logic               enc_start_reg, enc_start_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic complete;
  logic timed_out;
  logic is_last;

  // A finish only counts once it has been seen low for this file, so a level
  // left high by the previous file cannot complete the new one.
  assign complete  = armed_reg && enc_finish;
  assign timed_out = TO_EN && (to_cnt_reg == TO_LAST);
  assign is_last   = (file_index_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      hold_cnt_reg    <= '0;
      to_cnt_reg      <= '0;
      armed_reg       <= 1'b0;
      file_index_reg  <= FIRST;
      files_done_reg  <= '0;
      err_timeout_reg <= 1'b0;
      timeout_idx_reg <= '0;
      enc_start_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      to_cnt_reg      <= to_cnt_next;
      armed_reg       <= armed_next;
      file_index_reg  <= file_index_next;
      files_done_reg  <= files_done_next;
      err_timeout_reg <= err_timeout_next;
      timeout_idx_reg <= timeout_idx_next;
      enc_start_reg   <= enc_start_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    to_cnt_next      = to_cnt_reg;
    armed_next       = armed_reg;
    file_index_next  = file_index_reg;
    files_done_next  = files_done_reg;
    err_timeout_next = err_timeout_reg;
    timeout_idx_next = timeout_idx_reg;

    if (abort && (state_reg != S_IDLE)) begin
      // Abort beats completion and timeout: counters are left untouched.
      state_next      = S_IDLE;
      file_index_next = FIRST;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (go && !abort) begin
            state_next       = S_START;
            files_done_next  = '0;
            err_timeout_next = 1'b0;
            file_index_next  = FIRST;
            hold_cnt_next    = '0;
            armed_next       = 1'b0;
          end
        end

        S_START: begin
          if (!enc_finish) begin
            armed_next = 1'b1;
          end
          if (hold_cnt_reg == HOLD_LAST) begin
            state_next  = S_WAIT;
            to_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end

        S_WAIT: begin
          if (!enc_finish) begin
            armed_next = 1'b1;
          end
          if (complete) begin
            files_done_next = files_done_reg + IDX_W'(1);
            state_next      = is_last ? S_DONE : S_NEXT;
          end else if (timed_out) begin
            err_timeout_next = 1'b1;
            timeout_idx_next = file_index_reg;
            state_next       = (STOP_EN || is_last) ? S_DONE : S_NEXT;
          end else if (TO_EN) begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
          end
        end

        S_NEXT: begin
          // Index advances on the edge into START so it is stable for the
          // whole START/WAIT span of each file.
          file_index_next = file_index_reg + IDX_W'(1);
          state_next      = S_START;
          hold_cnt_next   = '0;
          armed_next      = 1'b0;
        end

        S_DONE: begin
          state_next      = S_IDLE;
          file_index_next = FIRST;
        end

        default: begin
          state_next      = S_IDLE;
          file_index_next = FIRST;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    enc_start_next = (state_next == S_START);
    busy_next      = (state_next != S_IDLE);
    done_next      = (state_next == S_DONE);
  end

  assign enc_start   = enc_start_reg;
  assign file_index  = file_index_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign files_done  = files_done_reg;
  assign err_timeout = err_timeout_reg;
  assign timeout_idx = timeout_idx_reg;

endmodule

// File: tb/tb_encoder_batch_sequencer.sv
// Directed bench for encoder_batch_sequencer. Two instances share the clock
// and reset: u_stop ends a batch on timeout, u_skip skips the timed-out file.
// A behavioural encoder per instance raises finish 21 cycles after the first
// enc_start cycle, unless that file index is configured to hang.
module tb_encoder_batch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       go_s         [2] = '{1'b0, 1'b0};
  logic       enc_finish_s [2] = '{1'b0, 1'b0};
  logic       enc_start_s  [2];
  logic [9:0] file_index_s [2];
  logic       busy_s       [2];
  logic       done_s       [2];
  logic [9:0] files_done_s [2];
  logic       err_s        [2];
  logic [9:0] to_idx_s     [2];

  int tests = 0;
  int fails = 0;

  // encoder model configuration (written by the stimulus only)
  int hang_idx   = -1;
  bit stale_mode = 1'b0;

  // monitor state (written by the monitor only)
  int cyc = 0;
  int nstarts   [2] = '{0, 0};
  int ndone     [2] = '{0, 0};
  int done_cyc  [2] = '{0, 0};
  int hold_bad  [2] = '{0, 0};
  int run_len   [2] = '{0, 0};
  int enc_cnt   [2] = '{0, 0};
  bit prev_start[2] = '{1'b0, 1'b0};
  int start_idx [2][256];
  int start_cyc [2][256];

  always #5 clk = ~clk;

  encoder_batch_sequencer #(
    .IDX_W(10), .FIRST_IDX(0), .NUM_FILES(8), .START_HOLD(3),
    .TIMEOUT(50), .TO_W(16), .STOP_ON_TO(1)
  ) u_stop (
    .clk(clk), .rst(rst), .go(go_s[0]), .abort(abort),
    .enc_finish(enc_finish_s[0]), .enc_start(enc_start_s[0]),
    .file_index(file_index_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .files_done(files_done_s[0]), .err_timeout(err_s[0]),
    .timeout_idx(to_idx_s[0])
  );

  encoder_batch_sequencer #(
    .IDX_W(10), .FIRST_IDX(0), .NUM_FILES(8), .START_HOLD(3),
    .TIMEOUT(50), .TO_W(16), .STOP_ON_TO(0)
  ) u_skip (
    .clk(clk), .rst(rst), .go(go_s[1]), .abort(abort),
    .enc_finish(enc_finish_s[1]), .enc_start(enc_start_s[1]),
    .file_index(file_index_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .files_done(files_done_s[1]), .err_timeout(err_s[1]),
    .timeout_idx(to_idx_s[1])
  );

  // Monitor + encoder model, evaluated on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (enc_start_s[d] && !prev_start[d]) begin
        if (nstarts[d] < 256) begin
          start_idx[d][nstarts[d]] = int'(file_index_s[d]);
          start_cyc[d][nstarts[d]] = cyc;
        end
        nstarts[d] = nstarts[d] + 1;
        enc_cnt[d] = 1;
        run_len[d] = 0;
        if (!stale_mode) enc_finish_s[d] = 1'b0;
      end else if (enc_cnt[d] != 0) begin
        enc_cnt[d] = enc_cnt[d] + 1;
      end
      if (enc_start_s[d]) begin
        run_len[d] = run_len[d] + 1;
      end else if (prev_start[d]) begin
        if (run_len[d] != 3) hold_bad[d] = hold_bad[d] + 1;
        run_len[d] = 0;
      end
      if (stale_mode && enc_cnt[d] == 6) enc_finish_s[d] = 1'b0;
      if (enc_cnt[d] == 21 && int'(file_index_s[d]) != hang_idx) enc_finish_s[d] = 1'b1;
      if (done_s[d]) begin
        ndone[d]    = ndone[d] + 1;
        done_cyc[d] = cyc;
      end
      prev_start[d] = enc_start_s[d];
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic pulse_go(input int d);
    go_s[d] = 1'b1;
    tick();
    go_s[d] = 1'b0;
  endtask

  task automatic run_until_done(input int d, input int budget);
    int n;
    n = 0;
    while (!done_s[d] && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (!done_s[d]) begin
      fails++;
      $display("FAIL done_wait[%0d]: no done pulse within %0d cycles", d, budget);
    end
  endtask

  task automatic wait_starts(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (nstarts[d] < target && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (nstarts[d] < target) begin
      fails++;
      $display("FAIL start_wait[%0d]: got %0d starts, expected %0d", d, nstarts[d], target);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      tests++; if (enc_start_s[d] !== 1'b0) begin fails++; $display("FAIL rst_enc_start[%0d]: got %b expected 0", d, enc_start_s[d]); end
      tests++; if (file_index_s[d] !== 10'd0) begin fails++; $display("FAIL rst_file_index[%0d]: got %0d expected 0", d, file_index_s[d]); end
      tests++; if (busy_s[d] !== 1'b0) begin fails++; $display("FAIL rst_busy[%0d]: got %b expected 0", d, busy_s[d]); end
      tests++; if (done_s[d] !== 1'b0) begin fails++; $display("FAIL rst_done[%0d]: got %b expected 0", d, done_s[d]); end
      tests++; if (files_done_s[d] !== 10'd0) begin fails++; $display("FAIL rst_files_done[%0d]: got %0d expected 0", d, files_done_s[d]); end
      tests++; if (err_s[d] !== 1'b0) begin fails++; $display("FAIL rst_err_timeout[%0d]: got %b expected 0", d, err_s[d]); end
      tests++; if (to_idx_s[d] !== 10'd0) begin fails++; $display("FAIL rst_timeout_idx[%0d]: got %0d expected 0", d, to_idx_s[d]); end
    end
    $display("[TB] test_reset done");
  endtask

  // Full batch on u_stop; used for both normal and stale-finish scenarios.
  task automatic run_full_batch(input string tag);
    int base, dbase;
    base  = nstarts[0];
    dbase = ndone[0];
    pulse_go(0);
    tests++; if (enc_start_s[0] !== 1'b1 || busy_s[0] !== 1'b1) begin fails++; $display("FAIL %s_first_start: got start=%b busy=%b expected 1/1", tag, enc_start_s[0], busy_s[0]); end
    run_until_done(0, 2000);
    tests++; if (busy_s[0] !== 1'b1) begin fails++; $display("FAIL %s_busy_at_done: got %b expected 1", tag, busy_s[0]); end
    tests++; if (nstarts[0] - base != 8) begin fails++; $display("FAIL %s_start_count: got %0d expected 8", tag, nstarts[0] - base); end
    for (int k = 0; k < 8; k++) begin
      tests++; if (start_idx[0][base + k] != k) begin fails++; $display("FAIL %s_index[%0d]: got %0d expected %0d", tag, k, start_idx[0][base + k], k); end
    end
    for (int k = 1; k < 8; k++) begin
      tests++; if (start_cyc[0][base + k] - start_cyc[0][base + k - 1] != 22) begin fails++; $display("FAIL %s_period[%0d]: got %0d expected 22", tag, k, start_cyc[0][base + k] - start_cyc[0][base + k - 1]); end
    end
    tests++; if (files_done_s[0] !== 10'd8) begin fails++; $display("FAIL %s_files_done: got %0d expected 8", tag, files_done_s[0]); end
    tests++; if (err_s[0] !== 1'b0) begin fails++; $display("FAIL %s_err_timeout: got %b expected 0", tag, err_s[0]); end
    tick();
    tests++; if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin fails++; $display("FAIL %s_after_done: got busy=%b done=%b expected 0/0", tag, busy_s[0], done_s[0]); end
    tests++; if (file_index_s[0] !== 10'd0) begin fails++; $display("FAIL %s_idx_after_done: got %0d expected 0", tag, file_index_s[0]); end
    repeat (5) tick();
    tests++; if (ndone[0] - dbase != 1) begin fails++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, ndone[0] - dbase); end
    tests++; if (hold_bad[0] != 0) begin fails++; $display("FAIL %s_start_hold: got %0d bad start widths expected 0", tag, hold_bad[0]); end
    tests++; if (files_done_s[0] !== 10'd8) begin fails++; $display("FAIL %s_files_done_hold: got %0d expected 8", tag, files_done_s[0]); end
  endtask

  task automatic test_normal();
    stale_mode = 1'b0;
    hang_idx   = -1;
    run_full_batch("normal");
    $display("[TB] test_normal done");
  endtask

  task automatic test_stale_finish();
    stale_mode = 1'b1;
    hang_idx   = -1;
    run_full_batch("stale");
    stale_mode = 1'b0;
    $display("[TB] test_stale_finish done");
  endtask

  task automatic test_timeout_stop();
    int base, dbase;
    hang_idx = 3;
    base  = nstarts[0];
    dbase = ndone[0];
    pulse_go(0);
    run_until_done(0, 2000);
    tests++; if (done_cyc[0] - start_cyc[0][base + 3] != 53) begin fails++; $display("FAIL tostop_wait_len: got %0d expected 53", done_cyc[0] - start_cyc[0][base + 3]); end
    tests++; if (err_s[0] !== 1'b1) begin fails++; $display("FAIL tostop_err: got %b expected 1", err_s[0]); end
    tests++; if (to_idx_s[0] !== 10'd3) begin fails++; $display("FAIL tostop_idx: got %0d expected 3", to_idx_s[0]); end
    tests++; if (files_done_s[0] !== 10'd3) begin fails++; $display("FAIL tostop_files_done: got %0d expected 3", files_done_s[0]); end
    repeat (30) tick();
    tests++; if (nstarts[0] - base != 4) begin fails++; $display("FAIL tostop_starts: got %0d expected 4", nstarts[0] - base); end
    tests++; if (ndone[0] - dbase != 1) begin fails++; $display("FAIL tostop_done_pulses: got %0d expected 1", ndone[0] - dbase); end
    hang_idx = -1;
    $display("[TB] test_timeout_stop done");
  endtask

  task automatic test_timeout_skip();
    int base, dbase;
    hang_idx = 3;
    base  = nstarts[1];
    dbase = ndone[1];
    pulse_go(1);
    run_until_done(1, 3000);
    tests++; if (file_index_s[1] !== 10'd7) begin fails++; $display("FAIL toskip_last_idx: got %0d expected 7", file_index_s[1]); end
    tests++; if (nstarts[1] - base != 8) begin fails++; $display("FAIL toskip_starts: got %0d expected 8", nstarts[1] - base); end
    for (int k = 4; k < 8; k++) begin
      tests++; if (start_idx[1][base + k] != k) begin fails++; $display("FAIL toskip_index[%0d]: got %0d expected %0d", k, start_idx[1][base + k], k); end
    end
    tests++; if (start_cyc[1][base + 4] - start_cyc[1][base + 3] != 54) begin fails++; $display("FAIL toskip_skip_gap: got %0d expected 54", start_cyc[1][base + 4] - start_cyc[1][base + 3]); end
    tests++; if (files_done_s[1] !== 10'd7) begin fails++; $display("FAIL toskip_files_done: got %0d expected 7", files_done_s[1]); end
    tests++; if (err_s[1] !== 1'b1) begin fails++; $display("FAIL toskip_err: got %b expected 1", err_s[1]); end
    tests++; if (to_idx_s[1] !== 10'd3) begin fails++; $display("FAIL toskip_idx: got %0d expected 3", to_idx_s[1]); end
    repeat (5) tick();
    tests++; if (ndone[1] - dbase != 1) begin fails++; $display("FAIL toskip_done_pulses: got %0d expected 1", ndone[1] - dbase); end
    hang_idx = -1;
    $display("[TB] test_timeout_skip done");
  endtask

  task automatic test_abort();
    int base, dbase, snap;
    base  = nstarts[0];
    dbase = ndone[0];
    pulse_go(0);
    wait_starts(0, base + 6, 1000);
    repeat (10) tick();
    tests++; if (file_index_s[0] !== 10'd5 || enc_start_s[0] !== 1'b0) begin fails++; $display("FAIL abort_in_wait: got idx=%0d start=%b expected 5/0", file_index_s[0], enc_start_s[0]); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if (busy_s[0] !== 1'b0 || enc_start_s[0] !== 1'b0) begin fails++; $display("FAIL abort_outputs: got busy=%b start=%b expected 0/0", busy_s[0], enc_start_s[0]); end
    tests++; if (files_done_s[0] !== 10'd5) begin fails++; $display("FAIL abort_files_done: got %0d expected 5", files_done_s[0]); end
    snap = nstarts[0];
    repeat (30) tick();
    tests++; if (ndone[0] != dbase) begin fails++; $display("FAIL abort_no_done: got %0d done pulses expected 0", ndone[0] - dbase); end
    tests++; if (nstarts[0] != snap) begin fails++; $display("FAIL abort_no_start: got %0d extra starts expected 0", nstarts[0] - snap); end
    pulse_go(0);
    tests++; if (files_done_s[0] !== 10'd0 || err_s[0] !== 1'b0) begin fails++; $display("FAIL restart_clear: got files_done=%0d err=%b expected 0/0", files_done_s[0], err_s[0]); end
    tests++; if (file_index_s[0] !== 10'd0 || enc_start_s[0] !== 1'b1) begin fails++; $display("FAIL restart_start: got idx=%0d start=%b expected 0/1", file_index_s[0], enc_start_s[0]); end
    run_until_done(0, 2000);
    tests++; if (files_done_s[0] !== 10'd8) begin fails++; $display("FAIL restart_files_done: got %0d expected 8", files_done_s[0]); end
    tick();
    $display("[TB] test_abort done");
  endtask

  task automatic test_reset_mid();
    int base, snap;
    base = nstarts[0];
    pulse_go(0);
    wait_starts(0, base + 3, 1000);
    tests++; if (file_index_s[0] !== 10'd2 || enc_start_s[0] !== 1'b1) begin fails++; $display("FAIL midrst_in_start: got idx=%0d start=%b expected 2/1", file_index_s[0], enc_start_s[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (enc_start_s[0] !== 1'b0) begin fails++; $display("FAIL midrst_enc_start: got %b expected 0", enc_start_s[0]); end
    tests++; if (busy_s[0] !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy_s[0]); end
    tests++; if (done_s[0] !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b expected 0", done_s[0]); end
    tests++; if (file_index_s[0] !== 10'd0) begin fails++; $display("FAIL midrst_file_index: got %0d expected 0", file_index_s[0]); end
    tests++; if (files_done_s[0] !== 10'd0) begin fails++; $display("FAIL midrst_files_done: got %0d expected 0", files_done_s[0]); end
    tests++; if (err_s[0] !== 1'b0) begin fails++; $display("FAIL midrst_err: got %b expected 0", err_s[0]); end
    tests++; if (to_idx_s[0] !== 10'd0) begin fails++; $display("FAIL midrst_timeout_idx: got %0d expected 0", to_idx_s[0]); end
    tests++; if (to_idx_s[1] !== 10'd0) begin fails++; $display("FAIL midrst_timeout_idx_skip: got %0d expected 0", to_idx_s[1]); end
    snap = nstarts[0];
    go_s[0] = 1'b1;
    abort   = 1'b1;
    tick();
    go_s[0] = 1'b0;
    abort   = 1'b0;
    tests++; if (busy_s[0] !== 1'b0 || enc_start_s[0] !== 1'b0) begin fails++; $display("FAIL goabort_idle: got busy=%b start=%b expected 0/0", busy_s[0], enc_start_s[0]); end
    repeat (5) tick();
    tests++; if (nstarts[0] != snap || busy_s[0] !== 1'b0) begin fails++; $display("FAIL goabort_stays_idle: got starts=%0d busy=%b expected 0/0", nstarts[0] - snap, busy_s[0]); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_normal();
    test_stale_finish();
    test_timeout_stop();
    test_timeout_skip();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
